// File: rtl/cheri_pkg.sv
// Purpose : shared types and helpers for the CHERI temporal-safety map controller.
// Latency : n/a (package).
// Backpressure: n/a (package).
package cheri_pkg;

   localparam int TSMAP_DW = 32;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WR   = 3'd2,
      RESP = 3'd3,
      ERR  = 3'd4
   } tsmap_st_e;

   // Bits set in mask take the new value, bits clear keep the old one.
   function automatic logic [TSMAP_DW-1:0] tsmap_merge(
      input logic [TSMAP_DW-1:0] old,
      input logic [TSMAP_DW-1:0] wdata,
      input logic [TSMAP_DW-1:0] mask
   );
      return (old & ~mask) | (wdata & mask);
   endfunction

endpackage

// File: rtl/cheri_tsmap_host_fsm.sv
// Purpose : host-port sequencer for the tsmap SRAM: read or masked read-modify-write.
// Latency : gnt->rvalid 2 cycles (read), 3 cycles (RMW), 1 cycle (out-of-range error).
// Backpressure: core reads win; issue and write-back wait while core_cs_i is high.
//
// Ports: host_* request/response handshake; core_cs_i is the core strobe used only
// to yield the SRAM; sram_req/we/idx/wdata ask the top for the SRAM port;
// wr_pend/pend_idx/pend_dat expose the word waiting in WR for forwarding.
module cheri_tsmap_host_fsm
   import cheri_pkg::*;
#(
   parameter int unsigned MapWords = 2048,
   parameter int          IdxW     = 11
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic            core_cs_i,
   input  logic            host_req_i,
   output logic            host_gnt_o,
   input  logic            host_we_i,
   input  logic [15:0]     host_idx_i,
   input  logic [31:0]     host_wdata_i,
   input  logic [31:0]     host_bmask_i,
   output logic            host_rvalid_o,
   output logic [31:0]     host_rdata_o,
   output logic            host_err_o,
   output logic            sram_req_o,
   output logic            sram_we_o,
   output logic [IdxW-1:0] sram_idx_o,
   output logic [31:0]     sram_wdata_o,
   input  logic [31:0]     sram_rdata_i,
   output logic            wr_pend_o,
   output logic [IdxW-1:0] pend_idx_o,
   output logic [31:0]     pend_dat_o
);

   tsmap_st_e       state_q, state_d;
   logic            we_q;
   logic [IdxW-1:0] idx_q;
   logic [31:0]     wdata_q, bmask_q, old_q, merge_q;
   logic            accept;
   logic            host_in_range;

   assign host_in_range = (32'(host_idx_i) < MapWords);

   always_comb begin
      state_d    = state_q;
      host_gnt_o = 1'b0;
      sram_req_o = 1'b0;
      sram_we_o  = 1'b0;
      accept     = 1'b0;
      case (state_q)
         IDLE: begin
            if (host_req_i) begin
               if (!host_in_range) begin
                  // No SRAM access needed, so the core strobe does not hold it off.
                  host_gnt_o = 1'b1;
                  state_d    = ERR;
               end else if (!core_cs_i) begin
                  host_gnt_o = 1'b1;
                  sram_req_o = 1'b1;
                  accept     = 1'b1;
                  state_d    = RD;
               end
            end
         end
         RD:   state_d = we_q ? WR : RESP;
         WR: begin
            if (!core_cs_i) begin
               sram_req_o = 1'b1;
               sram_we_o  = 1'b1;
               state_d    = RESP;
            end
         end
         RESP:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         bmask_q <= '0;
         old_q   <= '0;
         merge_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= host_we_i;
            idx_q   <= host_idx_i[IdxW-1:0];
            wdata_q <= host_wdata_i;
            bmask_q <= host_bmask_i;
         end
         if (state_q == RD) begin
            old_q   <= sram_rdata_i;
            merge_q <= tsmap_merge(sram_rdata_i, wdata_q, bmask_q);
         end
      end
   end

   // The only issue cycle is in IDLE, where the index comes straight from the host.
   assign sram_idx_o    = (state_q == WR) ? idx_q : host_idx_i[IdxW-1:0];
   assign sram_wdata_o  = sram_we_o ? merge_q : 32'h0;
   assign host_rvalid_o = (state_q == RESP) || (state_q == ERR);
   assign host_err_o    = (state_q == ERR);
   assign host_rdata_o  = (state_q == RESP) ? old_q : 32'h0;
   assign wr_pend_o     = (state_q == WR);
   assign pend_idx_o    = idx_q;
   assign pend_dat_o    = merge_q;

endmodule

// File: rtl/cheri_tsmap_ctrl.sv
// Purpose : owns the temporal-safety bitmap SRAM; core read port plus host read/RMW port.
// Latency : core read data 1 cycle after core_cs_i; host as in cheri_tsmap_host_fsm.
// Backpressure: core is never stalled; host is held off (gnt=0) while the core uses the SRAM.
//
// Ports: core_cs/idx -> core_rdata/core_oob (next cycle); host_req/gnt/we/idx/wdata/bmask
// -> host_rvalid/rdata/err; sram_cs/we/addr/wdata -> external SRAM, sram_rdata 1-cycle back.
module cheri_tsmap_ctrl
   import cheri_pkg::*;
#(
   parameter logic [31:0] DRamBase  = 32'h200f_0000,
   parameter logic [31:0] TSMapBase = 32'h200f_e000,
   parameter logic [31:0] TSMapTop  = 32'h2010_0000,
   parameter int          SramAddrW = 16
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 core_cs_i,
   input  logic [15:0]          core_idx_i,
   output logic [31:0]          core_rdata_o,
   output logic                 core_oob_o,
   input  logic                 host_req_i,
   output logic                 host_gnt_o,
   input  logic                 host_we_i,
   input  logic [15:0]          host_idx_i,
   input  logic [31:0]          host_wdata_i,
   input  logic [31:0]          host_bmask_i,
   output logic                 host_rvalid_o,
   output logic [31:0]          host_rdata_o,
   output logic                 host_err_o,
   output logic                 sram_cs_o,
   output logic                 sram_we_o,
   output logic [SramAddrW-1:0] sram_addr_o,
   output logic [31:0]          sram_wdata_o,
   input  logic [31:0]          sram_rdata_i
);

   localparam int unsigned MapWords = int'((TSMapTop - TSMapBase) >> 2);
   localparam int unsigned MapOffW  = int'((TSMapBase - DRamBase) >> 2);
   localparam int          IdxW     = $clog2(MapWords);
   localparam logic [SramAddrW-1:0] MapOffA = SramAddrW'(MapOffW);

   if (TSMapTop <= TSMapBase) begin : g_err_range
      $error("tsmap: TSMapTop must be above TSMapBase");
   end
   if ((TSMapBase < DRamBase) || ((TSMapBase & 32'h3) != 32'h0)) begin : g_err_base
      $error("tsmap: TSMapBase must be word-aligned and not below DRamBase");
   end
   if ((longint'(MapOffW) + longint'(MapWords)) > (64'd1 << SramAddrW)) begin : g_err_fit
      $error("tsmap: map does not fit in the SRAM address space");
   end
   if ((MapWords < 2) || (MapWords > 65536)) begin : g_err_size
      $error("tsmap: map size must be 2..65536 words");
   end

   logic            fsm_req, fsm_we, fsm_wr_pend;
   logic [IdxW-1:0] fsm_idx, fsm_pend_idx;
   logic [31:0]     fsm_wdata, fsm_pend_dat;

   cheri_tsmap_host_fsm #(
      .MapWords (MapWords),
      .IdxW     (IdxW)
   ) u_host_fsm (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .core_cs_i     (core_cs_i),
      .host_req_i    (host_req_i),
      .host_gnt_o    (host_gnt_o),
      .host_we_i     (host_we_i),
      .host_idx_i    (host_idx_i),
      .host_wdata_i  (host_wdata_i),
      .host_bmask_i  (host_bmask_i),
      .host_rvalid_o (host_rvalid_o),
      .host_rdata_o  (host_rdata_o),
      .host_err_o    (host_err_o),
      .sram_req_o    (fsm_req),
      .sram_we_o     (fsm_we),
      .sram_idx_o    (fsm_idx),
      .sram_wdata_o  (fsm_wdata),
      .sram_rdata_i  (sram_rdata_i),
      .wr_pend_o     (fsm_wr_pend),
      .pend_idx_o    (fsm_pend_idx),
      .pend_dat_o    (fsm_pend_dat)
   );

   logic        core_hit, core_oob, fwd_hit;
   logic        core_rd_q, fwd_q;
   logic [31:0] fwd_dat_q, hold_q;

   assign core_hit = core_cs_i && (32'(core_idx_i) < MapWords);
   assign core_oob = core_cs_i && !core_hit;
   // A core read of the word parked in WR must see the merged value, not the SRAM copy.
   assign fwd_hit  = core_hit && fsm_wr_pend && (core_idx_i[IdxW-1:0] == fsm_pend_idx);

   // The host FSM only requests while core_cs_i is low, so the core branch never drops one.
   always_comb begin
      sram_cs_o    = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = 32'h0;
      if (core_hit) begin
         sram_cs_o   = 1'b1;
         sram_addr_o = MapOffA + SramAddrW'(core_idx_i[IdxW-1:0]);
      end else if (fsm_req) begin
         sram_cs_o    = 1'b1;
         sram_we_o    = fsm_we;
         sram_addr_o  = MapOffA + SramAddrW'(fsm_idx);
         sram_wdata_o = fsm_wdata;
      end
   end

   // Data is taken from the SRAM the cycle it returns; hold_q keeps it afterwards.
   assign core_rdata_o = core_rd_q ? (fwd_q ? fwd_dat_q : sram_rdata_i) : hold_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         core_rd_q  <= 1'b0;
         fwd_q      <= 1'b0;
         fwd_dat_q  <= '0;
         hold_q     <= '0;
         core_oob_o <= 1'b0;
      end else begin
         core_rd_q  <= core_hit;
         fwd_q      <= fwd_hit;
         fwd_dat_q  <= fsm_pend_dat;
         core_oob_o <= core_oob;
         if (core_oob) begin
            hold_q <= 32'h0;
         end else if (core_rd_q) begin
            hold_q <= core_rdata_o;
         end
      end
   end

endmodule

// File: tb/tb_cheri_tsmap_ctrl.sv
module tb_cheri_tsmap_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        core_cs;
   logic [15:0] core_idx;
   logic [31:0] core_rdata;
   logic        core_oob;
   logic        host_req, host_gnt, host_we;
   logic [15:0] host_idx;
   logic [31:0] host_wdata, host_bmask;
   logic        host_rvalid;
   logic [31:0] host_rdata;
   logic        host_err;
   logic        sram_cs, sram_we;
   logic [15:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata = 32'h0;

   logic        pre_we = 1'b0;
   logic [15:0] pre_addr = 16'h0;
   logic [31:0] pre_dat = 32'h0;
   logic [31:0] mem [0:65535];
   int          wr_cnt = 0;
   int          checks = 0;
   int          failures = 0;
   int          wc_saved;

   always #5 clk = ~clk;

   cheri_tsmap_ctrl dut (
      .clk_i         (clk),
      .rstn_i        (rstn),
      .core_cs_i     (core_cs),
      .core_idx_i    (core_idx),
      .core_rdata_o  (core_rdata),
      .core_oob_o    (core_oob),
      .host_req_i    (host_req),
      .host_gnt_o    (host_gnt),
      .host_we_i     (host_we),
      .host_idx_i    (host_idx),
      .host_wdata_i  (host_wdata),
      .host_bmask_i  (host_bmask),
      .host_rvalid_o (host_rvalid),
      .host_rdata_o  (host_rdata),
      .host_err_o    (host_err),
      .sram_cs_o     (sram_cs),
      .sram_we_o     (sram_we),
      .sram_addr_o   (sram_addr),
      .sram_wdata_o  (sram_wdata),
      .sram_rdata_i  (sram_rdata)
   );

   // SRAM model: 1-cycle read latency, read-before-write; preload port when idle.
   always @(posedge clk) begin
      if (sram_cs) begin
         if (sram_we) begin
            mem[sram_addr] <= sram_wdata;
            wr_cnt <= wr_cnt + 1;
         end
         sram_rdata <= mem[sram_addr];
      end else if (pre_we) begin
         mem[pre_addr] <= pre_dat;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [31:0] d);
      pre_addr = a;
      pre_dat  = d;
      pre_we   = 1'b1;
      cyc();
      pre_we   = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; core_cs = 1'b0; core_idx = 16'h0;
      host_req = 1'b0; host_we = 1'b0; host_idx = 16'h0;
      host_wdata = 32'h0; host_bmask = 32'h0;
      #3;
      chk("rst_core_rdata", core_rdata, 32'h0);
      chk("rst_core_oob", 32'(core_oob), 32'h0);
      chk("rst_gnt", 32'(host_gnt), 32'h0);
      chk("rst_rvalid", 32'(host_rvalid), 32'h0);
      chk("rst_host_rdata", host_rdata, 32'h0);
      chk("rst_sram_cs", 32'(sram_cs), 32'h0);

      preload(16'h3805, 32'hDEADBEEF);
      preload(16'h3806, 32'h00C0FFEE);
      preload(16'h3810, 32'hF0F0F0F0);
      preload(16'h3820, 32'h12345678);
      preload(16'h3821, 32'h0BADF00D);
      preload(16'h3830, 32'hAAAA5555);
      preload(16'h3FFF, 32'h5A5A5A5A);
      rstn = 1'b1;

      // Core read, in range
      cyc(); core_cs = 1'b1; core_idx = 16'h0005; #3;
      chk("core_sram_cs", 32'(sram_cs), 32'h1);
      chk("core_sram_addr", 32'(sram_addr), 32'h3805);
      chk("core_sram_we", 32'(sram_we), 32'h0);
      cyc(); core_cs = 1'b0; #3;
      chk("core_rdata", core_rdata, 32'hDEADBEEF);
      chk("core_oob_inrange", 32'(core_oob), 32'h0);
      cyc(); #3;
      chk("core_rdata_hold", core_rdata, 32'hDEADBEEF);

      // Host RMW, no core traffic
      cyc(); host_req = 1'b1; host_we = 1'b1; host_idx = 16'h0010;
      host_wdata = 32'h0000FFFF; host_bmask = 32'h000000FF; #3;
      chk("rmw_gnt", 32'(host_gnt), 32'h1);
      chk("rmw_issue_addr", 32'(sram_addr), 32'h3810);
      chk("rmw_issue_we", 32'(sram_we), 32'h0);
      cyc(); host_req = 1'b0; #3;
      chk("rmw_rd_gnt", 32'(host_gnt), 32'h0);
      chk("rmw_rd_cs", 32'(sram_cs), 32'h0);
      chk("rmw_rd_rvalid", 32'(host_rvalid), 32'h0);
      cyc(); #3;
      chk("rmw_wr_we", 32'(sram_we), 32'h1);
      chk("rmw_wr_addr", 32'(sram_addr), 32'h3810);
      chk("rmw_wr_data", sram_wdata, 32'hF0F0F0FF);
      cyc(); #3;
      chk("rmw_rvalid", 32'(host_rvalid), 32'h1);
      chk("rmw_rdata", host_rdata, 32'hF0F0F0F0);
      chk("rmw_err", 32'(host_err), 32'h0);
      cyc(); #3;
      chk("rmw_rvalid_drop", 32'(host_rvalid), 32'h0);
      chk("rmw_mem", mem[16'h3810], 32'hF0F0F0FF);
      chk("rmw_wr_cnt", 32'(wr_cnt), 32'd1);
      cyc(); core_cs = 1'b1; core_idx = 16'h0010;
      cyc(); core_cs = 1'b0; #3;
      chk("rmw_core_readback", core_rdata, 32'hF0F0F0FF);

      // Host read held off by core traffic
      cyc(); core_cs = 1'b1; core_idx = 16'h0006;
      host_req = 1'b1; host_we = 1'b0; host_idx = 16'h0005; #3;
      chk("blk_gnt0", 32'(host_gnt), 32'h0);
      chk("blk_addr0", 32'(sram_addr), 32'h3806);
      for (int i = 1; i < 5; i++) begin
         cyc(); #3;
         chk("blk_gnt", 32'(host_gnt), 32'h0);
      end
      chk("blk_core_rdata", core_rdata, 32'h00C0FFEE);
      cyc(); core_cs = 1'b0; #3;
      chk("blk_gnt_release", 32'(host_gnt), 32'h1);
      chk("blk_issue_addr", 32'(sram_addr), 32'h3805);
      cyc(); host_req = 1'b0; #3;
      chk("rd_rvalid_early", 32'(host_rvalid), 32'h0);
      cyc(); #3;
      chk("rd_rvalid", 32'(host_rvalid), 32'h1);
      chk("rd_rdata", host_rdata, 32'hDEADBEEF);

      // RMW stuck in WR with core hitting the same word
      cyc(); host_req = 1'b1; host_we = 1'b1; host_idx = 16'h0020;
      host_wdata = 32'hFFFF0000; host_bmask = 32'h0F0F0F0F; #3;
      chk("fw_gnt", 32'(host_gnt), 32'h1);
      cyc(); host_req = 1'b0; core_cs = 1'b1; core_idx = 16'h0021; #3;
      chk("fw_rd_core_addr", 32'(sram_addr), 32'h3821);
      chk("fw_rd_we", 32'(sram_we), 32'h0);
      cyc(); core_idx = 16'h0020; #3;
      chk("fw_stall_we", 32'(sram_we), 32'h0);
      chk("fw_stall_addr", 32'(sram_addr), 32'h3820);
      chk("fw_rd_core_data", core_rdata, 32'h0BADF00D);
      cyc(); #3;
      chk("fw_data1", core_rdata, 32'h1F3F5070);
      chk("fw_stall_we2", 32'(sram_we), 32'h0);
      chk("fw_rvalid", 32'(host_rvalid), 32'h0);
      cyc(); core_cs = 1'b0; #3;
      chk("fw_data2", core_rdata, 32'h1F3F5070);
      chk("fw_wr_we", 32'(sram_we), 32'h1);
      chk("fw_wr_addr", 32'(sram_addr), 32'h3820);
      chk("fw_wr_data", sram_wdata, 32'h1F3F5070);
      cyc(); #3;
      chk("fw_resp_rvalid", 32'(host_rvalid), 32'h1);
      chk("fw_resp_rdata", host_rdata, 32'h12345678);
      chk("fw_mem", mem[16'h3820], 32'h1F3F5070);

      // Out-of-range host and core indices
      cyc(); host_req = 1'b1; host_we = 1'b0; host_idx = 16'h0800; #3;
      chk("oob_host_gnt", 32'(host_gnt), 32'h1);
      chk("oob_host_cs", 32'(sram_cs), 32'h0);
      cyc(); host_req = 1'b0; #3;
      chk("oob_host_rvalid", 32'(host_rvalid), 32'h1);
      chk("oob_host_err", 32'(host_err), 32'h1);
      chk("oob_host_rdata", host_rdata, 32'h0);
      cyc(); core_cs = 1'b1; core_idx = 16'h0900; #3;
      chk("oob_host_err_drop", 32'(host_err), 32'h0);
      chk("oob_core_cs", 32'(sram_cs), 32'h0);
      cyc(); core_cs = 1'b0; #3;
      chk("oob_core_pulse", 32'(core_oob), 32'h1);
      chk("oob_core_rdata", core_rdata, 32'h0);
      cyc(); #3;
      chk("oob_core_pulse_end", 32'(core_oob), 32'h0);
      chk("oob_core_rdata_hold", core_rdata, 32'h0);
      cyc(); core_cs = 1'b1; core_idx = 16'h07FF; #3;
      chk("top_idx_addr", 32'(sram_addr), 32'h3FFF);
      cyc(); core_cs = 1'b0; #3;
      chk("top_idx_data", core_rdata, 32'h5A5A5A5A);
      chk("top_idx_oob", 32'(core_oob), 32'h0);

      // Reset while a write is pending
      cyc(); host_req = 1'b1; host_we = 1'b1; host_idx = 16'h0030;
      host_wdata = 32'h11111111; host_bmask = 32'hFFFFFFFF; #3;
      chk("rst_rmw_gnt", 32'(host_gnt), 32'h1);
      cyc(); host_req = 1'b0; core_cs = 1'b1; core_idx = 16'h0005;
      cyc(); #3;
      chk("rst_rmw_stall", 32'(sram_we), 32'h0);
      wc_saved = wr_cnt;
      cyc(); rstn = 1'b0; core_cs = 1'b0; #1;
      chk("rst_mid_we", 32'(sram_we), 32'h0);
      chk("rst_mid_cs", 32'(sram_cs), 32'h0);
      chk("rst_mid_rdata", core_rdata, 32'h0);
      chk("rst_mid_rvalid", 32'(host_rvalid), 32'h0);
      cyc(); cyc(); rstn = 1'b1;
      cyc(); cyc(); #3;
      chk("rst_no_write", 32'(wr_cnt), 32'(wc_saved));
      chk("rst_mem_kept", mem[16'h3830], 32'hAAAA5555);
      chk("rst_post_rvalid", 32'(host_rvalid), 32'h0);
      cyc(); host_req = 1'b1; host_we = 1'b0; host_idx = 16'h0030; #3;
      chk("rst_idle_gnt", 32'(host_gnt), 32'h1);
      cyc(); host_req = 1'b0;
      cyc(); #3;
      chk("rst_post_rvalid2", 32'(host_rvalid), 32'h1);
      chk("rst_post_rdata", host_rdata, 32'hAAAA5555);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
